b_lut_seq: RTL

//  Sequential, parametrised nibble-substitution unit for the xc.lut family. A 16-entry x 4-bit

---
 rtl/b_lut_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/b_lut_seq.sv
// b_lut_seq: sequential 16x4-bit nibble substitution, NPC nibbles per cycle, constant latency.
// Optional feature macro B_LUT_SEQ_TABLE_HOLD_EN adds req_tbl_keep to reuse the previously loaded table.
module b_lut_seq #(
    parameter int XLEN = 32,
    parameter int NPC  = 2
) (
    input  logic            g_clk,
    input  logic            g_rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [63:0]     req_tbl,
`ifdef B_LUT_SEQ_TABLE_HOLD_EN
    input  logic            req_tbl_keep,
`endif
    input  logic [XLEN-1:0] req_idx,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);
    localparam int NNIB = XLEN / 4;
    localparam int L    = NNIB / NPC;
    localparam int CW   = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     tbl_q, tbl_d;
    logic [XLEN-1:0] idx_q, idx_d;
    logic [XLEN-1:0] res_q, res_d;

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tbl_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        idx_d   = idx_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        res_d   = '0;
                        idx_d   = req_idx;
`ifdef B_LUT_SEQ_TABLE_HOLD_EN
                        if (!req_tbl_keep) tbl_d = req_tbl;
`else
                        tbl_d = req_tbl;
`endif
                    end
                end
                RUN: begin
                    // Every nibble slot is visited each cycle, but only the NPC slots owned
                    // by the current count are written, so timing never depends on data.
                    for (int j = 0; j < NNIB; j++) begin
                        if (cnt_q == CW'(j / NPC)) begin
                            res_d[4*j +: 4] = tbl_q[{idx_q[4*j +: 4], 2'b00} +: 4];
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && !flush;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_result = rsp_valid ? res_q : '0;
    assign busy       = (state_q != IDLE);

endmodule
